// File: rtl/mips_pkg.sv
// Shared MIPS encodings, issue-controller state type and legal-set helpers
// used by the ALU issue controller and its decoder.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_EXEC,
      ST_WB
   } state_t;

   // NOR is deliberately absent: the downstream ALU does not implement it.
   function automatic logic is_legal_funct(input logic [5:0] funct);
      case (funct)
         FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV,
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
         FN_AND, FN_OR, FN_XOR, FN_SLT, FN_SLTU: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   function automatic logic is_legal_iop(input logic [5:0] op);
      return (op >= OP_ADDI) && (op <= OP_LUI);
   endfunction

   function automatic logic is_sign_ext_iop(input logic [5:0] op);
      return (op >= OP_ADDI) && (op <= OP_SLTIU);
   endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Pure combinational decode of a MIPS word into ALU controls, register
// fields, extended immediate and destination.
import mips_pkg::*;

module alu_issue_decode (
   input  logic [31:0] instr,
   output logic        legal,
   output logic        sig,
   output logic [5:0]  opcode,
   output logic [4:0]  shamt,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  dest,
   output logic        use_imm,
   output logic [31:0] imm_ext,
   output logic        ovf_check
);

   logic [5:0] op;
   logic [5:0] funct;

   assign op    = instr[31:26];
   assign funct = instr[5:0];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];

   always_comb begin
      legal     = 1'b0;
      sig       = 1'b0;
      opcode    = '0;
      shamt     = '0;
      dest      = '0;
      use_imm   = 1'b0;
      imm_ext   = '0;
      ovf_check = 1'b0;
      if (op == OP_RTYPE && is_legal_funct(funct)) begin
         legal     = 1'b1;
         sig       = 1'b1;
         opcode    = funct;
         shamt     = instr[10:6];
         dest      = instr[15:11];
         ovf_check = (funct == FN_ADD) || (funct == FN_SUB);
      end else if (is_legal_iop(op)) begin
         legal     = 1'b1;
         opcode    = op;
         dest      = instr[20:16];
         use_imm   = 1'b1;
         imm_ext   = is_sign_ext_iop(op) ? {{16{instr[15]}}, instr[15:0]}
                                         : {16'h0000, instr[15:0]};
         ovf_check = (op == OP_ADDI);
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one MIPS ALU instruction at a time, reads the
// register file, drives an external ALU and writes the result back.
import mips_pkg::*;

module alu_issue_ctrl #(
   parameter int RF_SYNC = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr,
   output logic        instr_ready,
   output logic [4:0]  rf_ra1,
   output logic [4:0]  rf_ra2,
   input  logic [31:0] rf_rd1,
   input  logic [31:0] rf_rd2,
   output logic [5:0]  alu_opcode,
   output logic        alu_sig,
   output logic [4:0]  alu_shamt,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        alu_overflow,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic        done,
   output logic        exc
);

   localparam logic SYNC_RF = (RF_SYNC != 0);

   state_t      state;
   state_t      next_state;
   logic [31:0] instr_q;
   logic [31:0] result_q;
   logic        ovf_q;
   logic [31:0] dec_in;
   logic        dec_legal;
   logic        dec_sig;
   logic [5:0]  dec_opcode;
   logic [4:0]  dec_shamt;
   logic [4:0]  dec_rs;
   logic [4:0]  dec_rt;
   logic [4:0]  dec_dest;
   logic        dec_use_imm;
   logic [31:0] dec_imm;
   logic        dec_ovf_check;
   logic        load_ops;
   logic        in_wb;

   // In IDLE the offered word is decoded so an illegal one can skip straight to WB.
   assign dec_in = (state == ST_IDLE) ? instr : instr_q;

   alu_issue_decode u_decode (
      .instr     (dec_in),
      .legal     (dec_legal),
      .sig       (dec_sig),
      .opcode    (dec_opcode),
      .shamt     (dec_shamt),
      .rs        (dec_rs),
      .rt        (dec_rt),
      .dest      (dec_dest),
      .use_imm   (dec_use_imm),
      .imm_ext   (dec_imm),
      .ovf_check (dec_ovf_check)
   );

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (instr_valid) next_state = dec_legal ? ST_READ : ST_WB;
         ST_READ: next_state = SYNC_RF ? ST_WAIT : ST_EXEC;
         ST_WAIT: next_state = ST_EXEC;
         ST_EXEC: next_state = ST_WB;
         ST_WB:   next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Operands are valid on the last cycle before EXEC in either RF mode.
   assign load_ops = (next_state == ST_EXEC) && (state != ST_EXEC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         instr_q    <= '0;
         alu_opcode <= '0;
         alu_sig    <= 1'b0;
         alu_shamt  <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         result_q   <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ST_IDLE && instr_valid) begin
            instr_q <= instr;
         end
         if (load_ops) begin
            alu_opcode <= dec_opcode;
            alu_sig    <= dec_sig;
            alu_shamt  <= dec_shamt;
            alu_a      <= rf_rd1;
            alu_b      <= dec_use_imm ? dec_imm : rf_rd2;
         end
         if (state == ST_EXEC) begin
            result_q <= alu_result;
            ovf_q    <= alu_overflow && dec_ovf_check;
         end
         if (state == ST_WB) begin
            alu_opcode <= '0;
            alu_sig    <= 1'b0;
            alu_shamt  <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
         end
      end
   end

   assign in_wb       = (state == ST_WB);
   assign instr_ready = (state == ST_IDLE) && !rst;
   assign rf_ra1      = (state == ST_READ || state == ST_WAIT) ? dec_rs : '0;
   assign rf_ra2      = (state == ST_READ || state == ST_WAIT) ? dec_rt : '0;
   assign done        = in_wb;
   assign exc         = in_wb && (!dec_legal || ovf_q);
   assign rf_we       = in_wb && dec_legal && !ovf_q && (dec_dest != 5'd0);
   assign rf_wa       = (in_wb && dec_legal) ? dec_dest : '0;
   assign rf_wd       = rf_we ? result_q : '0;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a synchronous register-file model
// and a behavioural ALU; expected values are hand-computed per vector.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr = '0;
   logic        instr_ready;
   logic [4:0]  rf_ra1;
   logic [4:0]  rf_ra2;
   logic [31:0] rf_rd1;
   logic [31:0] rf_rd2;
   logic [5:0]  alu_opcode;
   logic        alu_sig;
   logic [4:0]  alu_shamt;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        alu_overflow;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        done;
   logic        exc;

   logic [31:0] regs [32];
   int          vectors = 0;
   int          miscompares = 0;
   int          wb_events = 0;
   int          lat;
   logic [4:0]  read_ra1;
   logic [4:0]  read_ra2;

   alu_issue_ctrl #(.RF_SYNC(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .instr_ready  (instr_ready),
      .rf_ra1       (rf_ra1),
      .rf_ra2       (rf_ra2),
      .rf_rd1       (rf_rd1),
      .rf_rd2       (rf_rd2),
      .alu_opcode   (alu_opcode),
      .alu_sig      (alu_sig),
      .alu_shamt    (alu_shamt),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_result   (alu_result),
      .alu_overflow (alu_overflow),
      .rf_we        (rf_we),
      .rf_wa        (rf_wa),
      .rf_wd        (rf_wd),
      .done         (done),
      .exc          (exc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      rf_rd1 <= regs[rf_ra1];
      rf_rd2 <= regs[rf_ra2];
   end

   always @(negedge clk) begin
      if (done || rf_we) wb_events <= wb_events + 1;
   end

   // Reference ALU; it flags overflow on every add/sub so the DUT's masking is exercised.
   always_comb begin
      alu_result   = '0;
      alu_overflow = 1'b0;
      if (alu_sig) begin
         case (alu_opcode)
            6'h00: alu_result = alu_b << alu_shamt;
            6'h02: alu_result = alu_b >> alu_shamt;
            6'h03: alu_result = $signed(alu_b) >>> alu_shamt;
            6'h04: alu_result = alu_b << alu_a[4:0];
            6'h06: alu_result = alu_b >> alu_a[4:0];
            6'h20, 6'h21: begin
               alu_result   = alu_a + alu_b;
               alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            6'h22, 6'h23: begin
               alu_result   = alu_a - alu_b;
               alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            6'h24: alu_result = alu_a & alu_b;
            6'h25: alu_result = alu_a | alu_b;
            6'h26: alu_result = alu_a ^ alu_b;
            6'h2A: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            6'h2B: alu_result = {31'b0, alu_a < alu_b};
            default: alu_result = '0;
         endcase
      end else begin
         case (alu_opcode)
            6'h08, 6'h09: begin
               alu_result   = alu_a + alu_b;
               alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
            end
            6'h0A: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            6'h0B: alu_result = {31'b0, alu_a < alu_b};
            6'h0C: alu_result = alu_a & alu_b;
            6'h0D: alu_result = alu_a | alu_b;
            6'h0E: alu_result = alu_a ^ alu_b;
            6'h0F: alu_result = alu_b << 16;
            default: alu_result = '0;
         endcase
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Offers one word, waits (bounded) for done; leaves the WB-cycle outputs visible.
   task automatic applyStimulus(input logic [31:0] word);
      @(negedge clk);
      checkOutput("ready_before_transfer", 32'(instr_ready), 32'd1);
      instr_valid = 1'b1;
      instr       = word;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = '0;
      lat         = 1;
      read_ra1    = rf_ra1;
      read_ra2    = rf_ra2;
      while (!done && lat < 12) begin
         @(negedge clk);
         lat++;
      end
      checkOutput("done_seen", 32'(done), 32'd1);
   endtask

   task automatic checkIdleAfter();
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("idle_alu_opcode", 32'(alu_opcode), 32'd0);
      checkOutput("idle_alu_a", alu_a, 32'd0);
   endtask

   initial begin
      int ev0;
      for (int i = 0; i < 32; i++) regs[i] = '0;

      $display("[TB] reset");
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 32'(instr_ready), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_alu_b", alu_b, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_ready", 32'(instr_ready), 32'd1);

      $display("[TB] ADD r3 = r1 + r2");
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      applyStimulus(32'h00221820);
      checkOutput("add_latency", 32'(lat), 32'd4);
      checkOutput("add_ra1", 32'(read_ra1), 32'd1);
      checkOutput("add_ra2", 32'(read_ra2), 32'd2);
      checkOutput("add_sig", 32'(alu_sig), 32'd1);
      checkOutput("add_opcode", 32'(alu_opcode), 32'h20);
      checkOutput("add_alu_a", alu_a, 32'd5);
      checkOutput("add_alu_b", alu_b, 32'd7);
      checkOutput("add_we", 32'(rf_we), 32'd1);
      checkOutput("add_wa", 32'(rf_wa), 32'd3);
      checkOutput("add_wd", rf_wd, 32'd12);
      checkOutput("add_exc", 32'(exc), 32'd0);
      checkIdleAfter();

      $display("[TB] ADDI overflow");
      regs[1] = 32'h7FFFFFFF;
      applyStimulus(32'h20240001);
      checkOutput("addi_latency", 32'(lat), 32'd4);
      checkOutput("addi_alu_b", alu_b, 32'h00000001);
      checkOutput("addi_exc", 32'(exc), 32'd1);
      checkOutput("addi_we", 32'(rf_we), 32'd0);
      checkOutput("addi_wd", rf_wd, 32'd0);
      checkIdleAfter();

      $display("[TB] ANDI zero-extend");
      applyStimulus(32'h30258000);
      checkOutput("andi_alu_b", alu_b, 32'h00008000);
      checkOutput("andi_sig", 32'(alu_sig), 32'd0);
      checkOutput("andi_opcode", 32'(alu_opcode), 32'h0C);
      checkOutput("andi_wa", 32'(rf_wa), 32'd5);
      checkOutput("andi_wd", rf_wd, 32'h00008000);

      $display("[TB] SLTI sign-extend");
      applyStimulus(32'h2825FFFF);
      checkOutput("slti_alu_b", alu_b, 32'hFFFFFFFF);
      checkOutput("slti_sig", 32'(alu_sig), 32'd0);
      checkOutput("slti_we", 32'(rf_we), 32'd1);
      checkOutput("slti_wd", rf_wd, 32'd0);

      $display("[TB] SRA");
      regs[2] = 32'h80000000;
      applyStimulus(32'h00023103);
      checkOutput("sra_opcode", 32'(alu_opcode), 32'h03);
      checkOutput("sra_shamt", 32'(alu_shamt), 32'd4);
      checkOutput("sra_wa", 32'(rf_wa), 32'd6);
      checkOutput("sra_wd", rf_wd, 32'hF8000000);

      $display("[TB] ADDU ignores overflow");
      regs[2] = 32'd1;
      applyStimulus(32'h00222021);
      checkOutput("addu_exc", 32'(exc), 32'd0);
      checkOutput("addu_we", 32'(rf_we), 32'd1);
      checkOutput("addu_wa", 32'(rf_wa), 32'd4);
      checkOutput("addu_wd", rf_wd, 32'h80000000);

      $display("[TB] SUB overflow");
      regs[2] = 32'hFFFFFFFF;
      applyStimulus(32'h00221822);
      checkOutput("sub_exc", 32'(exc), 32'd1);
      checkOutput("sub_we", 32'(rf_we), 32'd0);
      checkOutput("sub_wd", rf_wd, 32'd0);

      $display("[TB] illegal LW");
      applyStimulus(32'h8C220000);
      checkOutput("lw_latency", 32'(lat), 32'd1);
      checkOutput("lw_exc", 32'(exc), 32'd1);
      checkOutput("lw_we", 32'(rf_we), 32'd0);
      checkIdleAfter();

      $display("[TB] illegal NOR");
      applyStimulus(32'h00221827);
      checkOutput("nor_latency", 32'(lat), 32'd1);
      checkOutput("nor_exc", 32'(exc), 32'd1);

      $display("[TB] write to $0");
      applyStimulus(32'h00000000);
      checkOutput("nop_latency", 32'(lat), 32'd4);
      checkOutput("nop_exc", 32'(exc), 32'd0);
      checkOutput("nop_we", 32'(rf_we), 32'd0);

      $display("[TB] reset during EXEC");
      regs[1] = 32'd5;
      regs[2] = 32'd7;
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = 32'h00221820;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = '0;
      repeat (2) @(negedge clk);
      checkOutput("exec_opcode", 32'(alu_opcode), 32'h20);
      checkOutput("exec_done", 32'(done), 32'd0);
      ev0 = wb_events;
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_exec_opcode", 32'(alu_opcode), 32'd0);
      checkOutput("rst_exec_alu_a", alu_a, 32'd0);
      checkOutput("rst_exec_alu_b", alu_b, 32'd0);
      checkOutput("rst_exec_ready", 32'(instr_ready), 32'd0);
      checkOutput("rst_exec_we", 32'(rf_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_exec_ready_release", 32'(instr_ready), 32'd1);
      repeat (5) @(negedge clk);
      checkOutput("rst_exec_no_wb", 32'(wb_events - ev0), 32'd0);
      checkOutput("rst_exec_still_ready", 32'(instr_ready), 32'd1);

      $display("[TB] recovery ADD");
      applyStimulus(32'h00221820);
      checkOutput("rec_latency", 32'(lat), 32'd4);
      checkOutput("rec_wd", rf_wd, 32'd12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: RF_SYNC, default 1, 1 = register-file read data valid one cycle after address, 0 = same cycle.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 instr_valid  in  1  instruction offered; instr  in  32  MIPS instruction word; instr_ready  out  1  block can accept.
REQ-005 rf_ra1, rf_ra2  out  5  register read addresses (rs, rt); rf_rd1, rf_rd2  in  32  read data.
REQ-006 alu_opcode  out  6, alu_sig  out  1, alu_shamt  out  5, alu_a  out  32, alu_b  out  32  drive the ALU.
REQ-007 alu_result  in  32, alu_overflow  in  1  combinational ALU response.
REQ-008 rf_we  out  1, rf_wa  out  5, rf_wd  out  32  register write-back port.
REQ-009 done  out  1  one-cycle completion pulse; exc  out  1  qualified by done: illegal instruction or arithmetic overflow.

Function
REQ-010 States IDLE, READ, WAIT, EXEC, WB; WAIT is entered only when RF_SYNC=1.
REQ-011 instr_ready SHALL be 1 only in IDLE with rst low; transfer occurs when instr_valid & instr_ready at a rising edge, latching instr.
REQ-012 Legal R-type (op=0): funct in {0x00,0x02,0x03,0x04,0x06,0x20-0x26,0x2A,0x2B}; alu_sig=1, alu_opcode=funct, alu_shamt=instr[10:6], alu_a=rs data, alu_b=rt data, dest=rd.
REQ-013 Legal I-type: op in 0x08-0x0F; alu_sig=0, alu_opcode=op, alu_shamt=0, alu_a=rs data, dest=rt.
REQ-014 alu_b for op 0x08-0x0B SHALL be sign-extended imm16; for op 0x0C-0x0F zero-extended imm16.
REQ-015 All other encodings (incl. funct 0x27, JR/JALR, loads, stores, jumps, branches) are illegal: transfer -> WB next cycle with done=1, exc=1, rf_we=0; no READ/EXEC.
REQ-016 Legal path: IDLE -> READ -> [WAIT] -> EXEC -> WB -> IDLE; WB is 3 cycles after transfer (RF_SYNC=0) or 4 cycles (RF_SYNC=1).
REQ-017 rf_ra1/rf_ra2 SHALL carry rs/rt from READ through end of WAIT; operand registers capture rf_rd1/rf_rd2 at the last edge of READ (RF_SYNC=0) or WAIT (RF_SYNC=1).
REQ-018 ALU outputs SHALL be registered, stable for the entire EXEC cycle, held through WB, and zero in IDLE.
REQ-019 alu_result and alu_overflow SHALL be sampled at the end of EXEC.
REQ-020 WB: done=1 for exactly one cycle; rf_we=1 with rf_wa=dest, rf_wd=sampled result, unless dest=0 or overflow.
REQ-021 Overflow (only ADD 0x20, SUB 0x22, ADDI 0x08) SHALL give exc=1, rf_we=0, rf_wd=0.
REQ-022 Writes to register 0 SHALL be suppressed (rf_we=0, exc=0, done=1); instr=0x00000000 is such a case.
REQ-023 Outputs rf_we, done, exc SHALL be 0 outside WB; the next transfer is possible in the cycle after WB.

Reset
REQ-024 rst SHALL force IDLE immediately, regardless of clock, from any state, including mid-EXEC/WB.
REQ-025 Reset values: all outputs 0 except instr_ready, which becomes 1 at the first cycle after rst deasserts; latched instruction and operands cleared.
REQ-026 An instruction in flight at reset SHALL be discarded with no rf_we and no done.

Structure
REQ-027 Shared package mips_pkg SHALL hold opcode and funct constants (ALU encoding), the state enum, and the legal-set definitions.
REQ-028 Combinational decode (legality, field extraction, immediate extension, dest select) SHALL be one sub-module, alu_issue_decode; the FSM and registers stay in alu_issue_ctrl.

Verification
REQ-029 ADD: RF_SYNC=1, r1=5, r2=7, instr 0x00221820 -> alu_sig=1, alu_opcode=0x20, WB 4 cycles after transfer, rf_wa=3, rf_wd=12, exc=0.
REQ-030 ADDI overflow: r1=0x7FFFFFFF, instr 0x20240001 -> alu_b=0x00000001, done=1, exc=1, rf_we=0.
REQ-031 Immediate extension: 0x30258000 -> alu_b=0x00008000; 0x2825FFFF -> alu_b=0xFFFFFFFF, alu_sig=0.
REQ-032 SRA: r2=0x80000000, instr 0x00023103 -> alu_opcode=0x03, alu_shamt=4, rf_wa=6, rf_wd=0xF8000000.
REQ-033 Illegal and $0 cases: 0x8C220000 -> done=1 and exc=1 one cycle after transfer, rf_we=0; 0x00000000 -> done=1, exc=0, rf_we=0.
REQ-034 Reset in EXEC: assert rst mid-cycle -> outputs 0 before the next edge, no done or rf_we, instr_ready=1 the first cycle after release.
